pipe_sequencer: RTL and testbench



---
 rtl/pipe_sequencer.sv | 123 ++++++++++++
 tb/tb_pipe_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
// Issue/sequencing controller for the two-stage (EX, WB) 8-bit pipeline:
// handshake intake, bubble insertion, stalls, halt/drain and retire counting.
module pipe_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall_req,
  input  logic             in_valid,
  input  logic [7:0]       in_instr,
  output logic             in_ready,
  output logic             ex_valid,
  output logic [7:0]       ex_instr,
  output logic             wb_valid,
  output logic [7:0]       wb_instr,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             rf_we,
  output logic [2:0]       rf_waddr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t     state;
  logic       accept;
  logic       in_is_halt;
  logic [1:0] wb_fwd_code;

  assign in_ready   = (state == RUN) && !stall_req;
  assign accept     = in_valid && in_ready;
  assign in_is_halt = (in_instr[7:6] == 2'b11);

  assign rf_we    = wb_valid && !stall_req && !wb_instr[7];
  assign rf_waddr = wb_instr[5:3];

  // A halt is consumed at accept, so it becomes a bubble rather than entering EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_instr <= 8'h00;
      wb_valid <= 1'b0;
      wb_instr <= 8'h00;
    end else if (!stall_req) begin
      wb_valid <= ex_valid;
      wb_instr <= ex_instr;
      if (accept && !in_is_halt) begin
        ex_valid <= 1'b1;
        ex_instr <= in_instr;
      end else begin
        ex_valid <= 1'b0;
        ex_instr <= 8'h00;
      end
    end
  end

  // Control FSM; busy/done are registered alongside the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      retired_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start && !stall_req)
        retired_cnt <= '0;
      else if (wb_valid && !stall_req)
        retired_cnt <= retired_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (start && !stall_req) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (accept && in_is_halt)
            state <= DRAIN;
        end
        DRAIN: begin
          if (!stall_req && !ex_valid && !wb_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (wb_instr[7:6])
      2'b00:   wb_fwd_code = 2'b10;
      2'b01:   wb_fwd_code = 2'b01;
      default: wb_fwd_code = 2'b00;
    endcase
  end

  // Only an add in EX reads registers; li's low field is an immediate.
  always_comb begin
    fwd_sel_a = 2'b00;
    fwd_sel_b = 2'b00;
    if (ex_valid && ex_instr[7:6] == 2'b01 && wb_valid) begin
      if (ex_instr[5:3] == wb_instr[5:3])
        fwd_sel_a = wb_fwd_code;
      if (ex_instr[2:0] == wb_instr[5:3])
        fwd_sel_b = wb_fwd_code;
    end
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: hand-computed expectations checked with
// immediate assertions, one step per clock, sampled just after the falling edge.
module tb_pipe_sequencer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stall_req;
  logic             in_valid;
  logic [7:0]       in_instr;
  logic             in_ready;
  logic             ex_valid;
  logic [7:0]       ex_instr;
  logic             wb_valid;
  logic [7:0]       wb_instr;
  logic [1:0]       fwd_sel_a;
  logic [1:0]       fwd_sel_b;
  logic             rf_we;
  logic [2:0]       rf_waddr;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] retired_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int rf_pulses    = 0;
  int done_pulses  = 0;

  pipe_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stall_req(stall_req),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .ex_valid(ex_valid), .ex_instr(ex_instr),
    .wb_valid(wb_valid), .wb_instr(wb_instr),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .busy(busy), .done(done), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle's inputs after the falling edge and tallies strobes.
  task automatic apply_stimulus(input logic st, input logic stl,
                                input logic vld, input logic [7:0] ins);
    @(negedge clk);
    start     = st;
    stall_req = stl;
    in_valid  = vld;
    in_instr  = ins;
    #1;
    if (rf_we) rf_pulses++;
    if (done)  done_pulses++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall_req = 1'b0; in_valid = 1'b1; in_instr = 8'h49;
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_ex_valid", ex_valid, 0);
    check_output("rst_ex_instr", ex_instr, 0);
    check_output("rst_wb_valid", wb_valid, 0);
    check_output("rst_wb_instr", wb_instr, 0);
    check_output("rst_fwd_a", fwd_sel_a, 0);
    check_output("rst_fwd_b", fwd_sel_b, 0);
    check_output("rst_rf_we", rf_we, 0);
    check_output("rst_rf_waddr", rf_waddr, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_cnt", retired_cnt, 0);
    rst = 1'b0;

    // Start cycle: IDLE does not accept even with in_valid high.
    apply_stimulus(1, 0, 1, 8'h0B);
    check_output("idle_in_ready", in_ready, 0);
    apply_stimulus(0, 0, 1, 8'h0B);
    check_output("run_in_ready", in_ready, 1);
    check_output("run_busy", busy, 1);
    check_output("start_no_accept", ex_valid, 0);
    apply_stimulus(0, 0, 1, 8'h51);
    check_output("li_in_ex", ex_instr, 8'h0B);
    check_output("li_ex_fwd_b", fwd_sel_b, 0);
    apply_stimulus(0, 0, 0, 8'h00);
    check_output("add_after_li_fwd_b", fwd_sel_b, 2'b10);
    check_output("add_after_li_fwd_a", fwd_sel_a, 2'b00);
    check_output("li_wb_rf_we", rf_we, 1);
    check_output("li_wb_waddr", rf_waddr, 1);
    check_output("cnt_d", retired_cnt, 0);
    apply_stimulus(0, 0, 1, 8'h4A);
    check_output("add_wb_waddr", rf_waddr, 2);
    check_output("bubble_ex", ex_valid, 0);
    check_output("cnt_e", retired_cnt, 1);
    apply_stimulus(0, 0, 1, 8'h59);
    check_output("bubble_wb_rf_we", rf_we, 0);
    check_output("cnt_f", retired_cnt, 2);
    apply_stimulus(0, 0, 1, 8'h4A);
    check_output("add_add_fwd_b", fwd_sel_b, 2'b01);
    check_output("add_add_fwd_a", fwd_sel_a, 2'b00);
    check_output("cnt_g", retired_cnt, 2);
    apply_stimulus(0, 0, 1, 8'h49);
    check_output("nomatch_fwd_a", fwd_sel_a, 0);
    apply_stimulus(0, 0, 1, 8'h88);
    check_output("r1r1_fwd_a", fwd_sel_a, 2'b01);
    check_output("r1r1_fwd_b", fwd_sel_b, 2'b01);
    apply_stimulus(0, 0, 1, 8'h49);
    check_output("nop_in_ex_fwd_a", fwd_sel_a, 0);
    apply_stimulus(0, 0, 0, 8'h00);
    check_output("nop_wb_valid", wb_valid, 1);
    check_output("nop_wb_fwd_a", fwd_sel_a, 0);
    check_output("nop_wb_fwd_b", fwd_sel_b, 0);
    check_output("nop_wb_rf_we", rf_we, 0);
    check_output("cnt_k", retired_cnt, 6);
    apply_stimulus(0, 0, 0, 8'h00);
    check_output("nop_counted", retired_cnt, 7);

    // Three-cycle stall with li r2 in WB and li r3 in EX.
    apply_stimulus(0, 0, 1, 8'h13);
    check_output("cnt_m", retired_cnt, 8);
    apply_stimulus(0, 0, 1, 8'h1C);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 1, 1, 8'h25);
      check_output("stall_in_ready", in_ready, 0);
      check_output("stall_ex", ex_instr, 8'h1C);
      check_output("stall_wb", wb_instr, 8'h13);
      check_output("stall_rf_we", rf_we, 0);
      check_output("stall_cnt", retired_cnt, 8);
    end
    apply_stimulus(0, 0, 1, 8'h25);
    check_output("resume_in_ready", in_ready, 1);
    check_output("resume_rf_we", rf_we, 1);
    check_output("resume_waddr", rf_waddr, 2);
    apply_stimulus(0, 0, 1, 8'hC0);
    check_output("resume_ex", ex_instr, 8'h25);
    check_output("resume_wb", wb_instr, 8'h1C);
    check_output("cnt_s", retired_cnt, 9);
    apply_stimulus(0, 0, 0, 8'h00);
    check_output("drain_in_ready", in_ready, 0);
    check_output("drain_busy", busy, 1);
    check_output("halt_not_in_ex", ex_valid, 0);
    check_output("drain_wb", wb_instr, 8'h25);
    check_output("drain_done", done, 0);
    apply_stimulus(0, 0, 0, 8'h00);
    check_output("drain_empty_done", done, 0);
    apply_stimulus(0, 0, 0, 8'h00);
    check_output("done_pulse", done, 1);
    check_output("done_busy", busy, 0);
    check_output("halt_not_counted", retired_cnt, 11);
    apply_stimulus(0, 0, 0, 8'h00);
    check_output("idle_done_low", done, 0);

    // Program of three li then halt, with a stall in DONE.
    rf_pulses = 0; done_pulses = 0;
    apply_stimulus(1, 0, 0, 8'h00);
    apply_stimulus(0, 0, 1, 8'h08);
    apply_stimulus(0, 0, 1, 8'h10);
    apply_stimulus(0, 0, 1, 8'h18);
    apply_stimulus(0, 0, 1, 8'hC0);
    apply_stimulus(0, 0, 0, 8'h00);
    apply_stimulus(0, 0, 0, 8'h00);
    apply_stimulus(0, 1, 0, 8'h00);
    check_output("prog_done", done, 1);
    apply_stimulus(1, 0, 0, 8'h00);
    check_output("prog_rf_pulses", rf_pulses, 3);
    check_output("prog_done_pulses", done_pulses, 1);
    check_output("prog_cnt", retired_cnt, 3);
    check_output("prog_idle_done", done, 0);
    check_output("prog_idle_busy", busy, 0);
    apply_stimulus(0, 0, 1, 8'h08);
    check_output("restart_in_ready", in_ready, 1);
    check_output("restart_cnt", retired_cnt, 0);

    // Reset while draining.
    apply_stimulus(0, 0, 1, 8'hC0);
    apply_stimulus(0, 0, 0, 8'h00);
    check_output("pre_rst_wb_valid", wb_valid, 1);
    check_output("pre_rst_rf_we", rf_we, 1);
    rst = 1'b1;
    #1;
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_wb_valid", wb_valid, 0);
    check_output("mid_rst_rf_we", rf_we, 0);
    rf_pulses = 0;
    apply_stimulus(0, 0, 0, 8'h00);
    rst = 1'b0;
    apply_stimulus(0, 0, 1, 8'h08);
    apply_stimulus(0, 0, 1, 8'h08);
    check_output("post_rst_in_ready", in_ready, 0);
    check_output("post_rst_ex", ex_valid, 0);
    check_output("post_rst_rf_pulses", rf_pulses, 0);
    apply_stimulus(1, 0, 1, 8'h08);
    apply_stimulus(0, 0, 1, 8'h08);
    apply_stimulus(0, 0, 0, 8'h00);
    check_output("clean_start_ex", ex_instr, 8'h08);
    check_output("clean_start_cnt", retired_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
